// File: rtl/dark_channel_stream.sv
// dark_channel_stream
//   Streaming dark-channel engine for the dehazing path. Each accepted RGB
//   pixel is reduced to its channel minimum. That minimum is then eroded by
//   a trailing WIN x WIN window, which is clipped at the top and left frame
//   edges. One sample is produced per input pixel, with a fixed 3-cycle
//   latency.
//
// Ports
//   sys_clk    clock, rising edge
//   sys_rst    synchronous active-high reset
//   win_en     1 = windowed minimum, 0 = per-pixel minimum (sampled with in_valid)
//   in_valid   input pixel strobe, no back-pressure
//   in_sof     start of frame, qualified by in_valid
//   in_r/g/b   colour channels, CH_W bits each
//   out_valid  output sample strobe
//   out_sof    output sample is pixel (0,0)
//   out_eof    output sample is pixel (IMG_W-1, IMG_H-1)
//   out_dark   dark-channel sample
//   sof_err    in_sof seen while the position counters were not at (0,0)
module dark_channel_stream #(
    parameter int CH_W  = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 3
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            win_en,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [CH_W-1:0] in_r,
    input  logic [CH_W-1:0] in_g,
    input  logic [CH_W-1:0] in_b,
    output logic            out_valid,
    output logic            out_sof,
    output logic            out_eof,
    output logic [CH_W-1:0] out_dark,
    output logic            sof_err
);

    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NLB = (WIN > 1) ? WIN - 1 : 1;

    function automatic logic [CH_W-1:0] min2(input logic [CH_W-1:0] a,
                                             input logic [CH_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Position tracking: in_sof forces the accepted pixel to (0,0)
    logic [XW-1:0] pos_x, x_cur;
    logic [YW-1:0] pos_y, y_cur;
    logic          at_origin;

    always_comb begin
        at_origin = (pos_x == '0) && (pos_y == '0);
        x_cur     = in_sof ? '0 : pos_x;
        y_cur     = in_sof ? '0 : pos_y;
    end

    assign sof_err = in_valid & in_sof & ~at_origin & ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (in_valid) begin
            if (x_cur == XW'(IMG_W - 1)) begin
                pos_x <= '0;
                pos_y <= (y_cur == YW'(IMG_H - 1)) ? '0 : y_cur + YW'(1);
            end else begin
                pos_x <= x_cur + XW'(1);
                pos_y <= y_cur;
            end
        end
    end

    // ---- S1: channel minimum and position ----
    logic            vld_p0, wen_p0, first_p0, last_p0;
    logic [CH_W-1:0] m_p0;
    logic [XW-1:0]   x_p0;
    logic [YW-1:0]   y_p0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) vld_p0 <= 1'b0;
        else         vld_p0 <= in_valid;
    end

    always_ff @(posedge sys_clk) begin
        if (in_valid) begin
            m_p0     <= min2(min2(in_r, in_g), in_b);
            x_p0     <= x_cur;
            y_p0     <= y_cur;
            wen_p0   <= win_en;
            first_p0 <= (x_cur == '0) && (y_cur == '0);
            last_p0  <= (x_cur == XW'(IMG_W - 1)) && (y_cur == YW'(IMG_H - 1));
        end
    end

    // Line buffers form a cascade: buffer k holds row y-1-k at each column.
    // The read is registered alongside S1 (address x_cur). The write happens
    // one cycle later at x_p0. Consecutive pixels use different columns, so
    // the read always returns the old row.
    logic [CH_W-1:0] rd_p0 [NLB];

    generate
        if (WIN > 1) begin : g_lbuf
            for (genvar k = 0; k < WIN - 1; k++) begin : g_row
                logic [CH_W-1:0] mem [IMG_W];
                logic [CH_W-1:0] wr_d;
                logic [CH_W-1:0] rd_q;

                if (k == 0) begin : g_head
                    assign wr_d = m_p0;
                end else begin : g_tail
                    assign wr_d = rd_p0[k-1];
                end

                always_ff @(posedge sys_clk) begin
                    if (vld_p0)   mem[x_p0] <= wr_d;
                    if (in_valid) rd_q      <= mem[x_cur];
                end

                assign rd_p0[k] = rd_q;
            end
        end else begin : g_nolb
            assign rd_p0[0] = '0;
        end
    endgenerate

    // ---- S2: vertical minimum, rows above y=0 masked ----
    logic [CH_W-1:0] v_nxt;

    always_comb begin
        v_nxt = m_p0;
        for (int k = 1; k < WIN; k++)
            if (y_p0 >= YW'(k)) v_nxt = min2(v_nxt, rd_p0[k-1]);
    end

    logic            vld_p1, wen_p1, first_p1, last_p1;
    logic [CH_W-1:0] v_p1, m_p1;
    logic [XW-1:0]   x_p1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) vld_p1 <= 1'b0;
        else         vld_p1 <= vld_p0;
    end

    always_ff @(posedge sys_clk) begin
        if (vld_p0) begin
            v_p1     <= v_nxt;
            m_p1     <= m_p0;
            x_p1     <= x_p0;
            wen_p1   <= wen_p0;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
        end
    end

    // ---- S3: horizontal minimum over past column minima, no line wrap ----
    logic [CH_W-1:0] h_hist_p1 [NLB];
    logic [CH_W-1:0] d_nxt;

    always_comb begin
        d_nxt = v_p1;
        for (int j = 1; j < WIN; j++)
            if (x_p1 >= XW'(j)) d_nxt = min2(d_nxt, h_hist_p1[j-1]);
    end

    always_ff @(posedge sys_clk) begin
        if (vld_p1) begin
            h_hist_p1[0] <= v_p1;
            for (int j = 1; j < NLB; j++) h_hist_p1[j] <= h_hist_p1[j-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_dark  <= '0;
        end else begin
            out_valid <= vld_p1;
            out_sof   <= vld_p1 & first_p1;
            out_eof   <= vld_p1 & last_p1;
            if (vld_p1) out_dark <= wen_p1 ? d_nxt : m_p1;
        end
    end

endmodule

// File: doc/dark_channel_stream.md
Name: dark_channel_stream

Overview:
- Streaming dark-channel engine, parametrised successor to the fixed RGB332 per-byte minimum stage.
- Accepts one RGB pixel per valid cycle (per-channel width CH_W) and computes the per-pixel channel minimum.
- Applies a WIN x WIN trailing minimum (erosion) filter using on-chip line buffers, then emits one dark-channel sample per input pixel.
- Sits between the UART pixel assembler and the frame buffer in the dehazing path.

Parameters:
- CH_W, 8, bits per colour channel and per output sample.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- WIN, 3, filter window size; legal values 1, 3, 5. Implies WIN-1 line buffers of IMG_W x CH_W.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous active-high reset.
- win_en  in  1  1 = WIN x WIN filter; 0 = per-pixel minimum only. Sampled per pixel alongside in_valid.
- in_valid  in  1  input pixel strobe; no back-pressure.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_r  in  CH_W  red.
- in_g  in  CH_W  green.
- in_b  in  CH_W  blue.
- out_valid  out  1  output sample strobe.
- out_sof  out  1  first pixel of output frame.
- out_eof  out  1  last pixel of output frame (x=IMG_W-1, y=IMG_H-1).
- out_dark  out  CH_W  dark-channel value.
- sof_err  out  1  one-cycle pulse: in_sof arrived when the position counter was not at (0,0).

Behaviour:
- Reset: out_valid, out_sof, out_eof, sof_err and out_dark are 0. Position counters are (0,0). Pipeline valid bits are cleared. Line-buffer contents are don't-care, since row qualification masks them.
- Position counters x, y advance only on in_valid.
  - x wraps IMG_W-1 -> 0 and increments y.
  - y wraps IMG_H-1 -> 0.
- in_sof with in_valid forces the current pixel to position (0,0) and the counters continue from (1,0).
  - If the counters were not at (0,0), sof_err pulses in the same cycle the pixel is accepted.
- Pipeline, fixed latency of 3 cycles from in_valid to out_valid, independent of input gaps:
  - S1: m = min(r, g, b), registered with its x, y and win_en.
  - S2: write m into the line buffer for the current row at address x. Read the WIN-1 previous rows at address x. Vertical min v = min of m and the previous rows k = 1..WIN-1. A row k is included only if y >= k.
  - S3: horizontal shift register (depth WIN-1) of past v values, advanced only on S2-valid. Result d = min of v and the previous j = 1..WIN-1 samples. Sample j is included only if x >= j, so there is no wrap across lines.
- Window is trailing: output(x,y) = min over rows y-WIN+1..y and columns x-WIN+1..x, clipped to the frame. Excluded neighbours behave as all-ones (2^CH_W - 1).
- win_en=0 or WIN=1: out_dark = m, with the same 3-cycle latency. Line buffers are still written, so toggling win_en mid-frame yields correct filtered output from the next pixel on.
- out_sof and out_eof are aligned with out_valid for the pixels at (0,0) and (IMG_W-1, IMG_H-1).
- Simultaneous write/read to the same line-buffer address: the read returns the old row (read-before-write).
- Arithmetic: comparisons are unsigned, and there is no width growth.
- Reset mid-frame: the pipeline is flushed (no out_valid for in-flight pixels). The next pixel is treated as (0,0) whether or not in_sof is asserted. Old line data is masked by y=0.

Test Plan:
- Reset then a single pixel r=200, g=50, b=90 with in_sof, win_en=0 -> out_valid exactly 3 cycles later, out_dark=50, out_sof=1, sof_err=0.
- Full 640x480 frame, win_en=1, WIN=3, all pixels min=100 except (10,10)=5 -> out_dark=5 at positions x 10..12, y 10..12; 100 everywhere else; out_eof on the 307200th output only.
- Row 0 / column 0 clipping: frame with (0,0)=0 and all others 255 -> outputs (0,0), (1,0), (2,0), (0,1), (1,1), (2,2) equal 0; (3,0) and (0,3) equal 255; no contamination from the previous frame's last lines.
- Gapped input: the same frame with in_valid asserted on random 30% of cycles -> output sequence bit-identical to the gapless run; every out_valid exactly 3 cycles after its in_valid.
- in_sof asserted at pixel 1000 of a frame -> sof_err pulses once; that pixel emerges with out_sof=1; the next frame aligns correctly and no further sof_err.
- sys_rst asserted mid-line at x=300, y=7 for 1 cycle -> no out_valid for the 3 cycles after; the next pixel is treated as (0,0) and output equals that pixel's own min, unfiltered by stale rows.
